// File: rtl/dct_pkg.sv
// Constants shared by the DCT datapath stages and the transpose buffer.
package dct_pkg;

    localparam int unsigned DCT_N = 8;
    localparam int unsigned TP_W  = 12;

    localparam logic MODE_ROW = 1'b0;
    localparam logic MODE_COL = 1'b1;

endpackage

// File: rtl/tp_bank.sv
// One N x N element bank of the transpose buffer: full-row write port, row/column read port.
module tp_bank
    import dct_pkg::*;
#(
    parameter  int unsigned N  = DCT_N,
    parameter  int unsigned W  = TP_W,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [CW-1:0]   wrow,
    input  logic [N*W-1:0]  wdata,
    input  logic [CW-1:0]   ridx,
    input  logic            rmode,
    output logic [N*W-1:0]  rdata
);

    logic [W-1:0] mem [N][N];

    // Row write: element k of the input vector lands in column k
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < N; k++) begin
                mem[wrow][k] <= wdata[k*W +: W];
            end
        end
    end

    // Column mode gathers element r from row r; row mode returns row ridx unchanged
    always_comb begin
        rdata = '0;
        for (int r = 0; r < N; r++) begin
            if (rmode == MODE_COL) begin
                rdata[r*W +: W] = mem[r][ridx];
            end else begin
                rdata[r*W +: W] = mem[ridx][r];
            end
        end
    end

endmodule

// File: rtl/tp_pingpong_buffer.sv
// Ping-pong transpose buffer between row-DCT and column-DCT: one bank fills while the other drains.
module tp_pingpong_buffer
    import dct_pkg::*;
#(
    parameter  int unsigned N  = DCT_N,
    parameter  int unsigned W  = TP_W,
    localparam int unsigned CW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N*W-1:0]  in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            transpose,
    output logic [N*W-1:0]  out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic [CW-1:0]   out_idx
);

    logic           wr_bank;
    logic           rd_bank;
    logic [CW-1:0]  wr_row;
    logic [CW-1:0]  rd_col;
    logic [1:0]     full;
    logic [1:0]     mode;
    logic [1:0]     full_nxt;

    logic           wr_fire;
    logic           rd_fire;
    logic           wr_end;
    logic           rd_end;
    logic [N*W-1:0] bank_rdata [2];

    // Handshake status comes straight from registered flags; a freed bank is seen next cycle
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];
    assign out_idx   = rd_col;
    assign out_last  = out_valid && (rd_col == CW'(N-1));
    assign out_data  = bank_rdata[rd_bank];

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;
    assign wr_end  = wr_fire && (wr_row == CW'(N-1));
    assign rd_end  = rd_fire && (rd_col == CW'(N-1));

    for (genvar b = 0; b < 2; b++) begin : g_bank
        tp_bank #(.N(N), .W(W)) u_bank (
            .clk   (clk),
            .we    (wr_fire && (wr_bank == 1'(b))),
            .wrow  (wr_row),
            .wdata (in_data),
            .ridx  (rd_col),
            .rmode (mode[b]),
            .rdata (bank_rdata[b])
        );
    end

    // Fill and drain always target different banks, so set and clear never collide
    always_comb begin
        full_nxt = full;
        if (wr_end) full_nxt[wr_bank] = 1'b1;
        if (rd_end) full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank <= 1'b0;
            wr_row  <= '0;
            rd_bank <= 1'b0;
            rd_col  <= '0;
            full    <= 2'b00;
            mode    <= {MODE_ROW, MODE_ROW};
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_row <= wr_end ? '0 : CW'(wr_row + 1'b1);
                if (wr_row == '0) mode[wr_bank] <= transpose;
                if (wr_end) wr_bank <= ~wr_bank;
            end
            if (rd_fire) begin
                rd_col <= rd_end ? '0 : CW'(rd_col + 1'b1);
                if (rd_end) rd_bank <= ~rd_bank;
            end
        end
    end

endmodule

// File: tb/tb_tp_pingpong_buffer.sv
// Directed and randomized-handshake bench for the ping-pong transpose buffer (N=8, W=12).
module tb_tp_pingpong_buffer;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 12;
    localparam int unsigned NW = N*W;
    localparam int unsigned CW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [NW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    logic           transpose;
    logic [NW-1:0]  out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic [CW-1:0]  out_idx;

    int nvec = 0;
    int nerr = 0;

    // observations taken at the falling edge, before the next rising edge acts on them
    logic [NW-1:0]  obs_data;
    logic           obs_ir, obs_ov, obs_last;
    logic [CW-1:0]  obs_idx;
    bit             wfire, rfire;

    // reference model: rows of the block being filled, expected output queue, read index
    logic [W-1:0]   m_blk [N][N];
    int             m_row = 0;
    logic           m_mode = 1'b0;
    logic [NW-1:0]  exp_q [$];
    int             ridx = 0;
    bit             exp_ok;
    logic [NW-1:0]  exp_v;
    logic [CW-1:0]  exp_idx;

    always #5 clk = ~clk;

    tp_pingpong_buffer #(.N(N), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .transpose (transpose),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_idx   (out_idx)
    );

    function automatic logic [NW-1:0] mkrow(input int r, input int tag);
        logic [NW-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(tag*128 + 16*r + k);
        return v;
    endfunction

    // one cycle: sample outputs, apply inputs, advance the reference model
    task automatic drive(input logic iv, input logic [NW-1:0] d, input logic tr, input logic ordy);
        logic [NW-1:0] e;
        @(negedge clk);
        obs_ir   = in_ready;
        obs_ov   = out_valid;
        obs_last = out_last;
        obs_idx  = out_idx;
        obs_data = out_data;
        in_valid  = iv;
        in_data   = d;
        transpose = tr;
        out_ready = ordy;
        wfire = iv && obs_ir;
        rfire = obs_ov && ordy;
        if (wfire) begin
            if (m_row == 0) m_mode = tr;
            for (int k = 0; k < N; k++) m_blk[m_row][k] = d[k*W +: W];
            if (m_row == N-1) begin
                for (int v = 0; v < N; v++) begin
                    for (int j = 0; j < N; j++) e[j*W +: W] = m_mode ? m_blk[j][v] : m_blk[v][j];
                    exp_q.push_back(e);
                end
                m_row = 0;
            end else begin
                m_row++;
            end
        end
        if (rfire) begin
            exp_ok  = exp_q.size() != 0;
            exp_v   = exp_ok ? exp_q.pop_front() : '0;
            exp_idx = CW'(ridx);
            ridx    = (ridx + 1) % N;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; transpose = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        m_row = 0;
        ridx  = 0;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        nvec++; if (out_last !== 1'b0) begin nerr++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        nvec++; if (out_idx !== 3'd0) begin nerr++; $display("FAIL reset_out_idx: got %0d want 0", out_idx); end
    endtask

    task automatic test_single_transpose();
        logic [NW-1:0] want;
        for (int r = 0; r < N; r++) begin
            drive(1'b1, mkrow(r, 1), 1'b1, 1'b1);
            nvec++;
            if (obs_ov !== 1'b0 || obs_ir !== 1'b1) begin
                nerr++; $display("FAIL single_fill: row %0d out_valid=%b in_ready=%b want 0/1", r, obs_ov, obs_ir);
            end
        end
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) want[r*W +: W] = W'(128 + 16*r + c);
            drive(1'b0, '0, 1'b0, 1'b1);
            nvec++;
            if (obs_ov !== 1'b1 || obs_data !== want || obs_idx !== CW'(c) || obs_last !== (c == N-1)) begin
                nerr++; $display("FAIL single_col: col %0d valid=%b idx=%0d last=%b data=%h want data=%h", c, obs_ov, obs_idx, obs_last, obs_data, want);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        nvec++; if (obs_ov !== 1'b0) begin nerr++; $display("FAIL single_end: out_valid=%b want 0", obs_ov); end
    endtask

    task automatic test_passthrough();
        for (int r = 0; r < N; r++) drive(1'b1, mkrow(r, 2), (r % 2) == 1, 1'b1);
        for (int k = 0; k < N; k++) begin
            drive(1'b0, '0, 1'b1, 1'b1);
            nvec++;
            if (obs_ov !== 1'b1 || obs_data !== mkrow(k, 2) || obs_idx !== CW'(k) || obs_last !== (k == N-1)) begin
                nerr++; $display("FAIL pass_row: row %0d valid=%b idx=%0d data=%h want %h", k, obs_ov, obs_idx, obs_data, mkrow(k, 2));
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        int sent = 0, got = 0, bad_ir = 0;
        bit saw_final = 0, rise_done = 0;
        for (int i = 0; i < 30; i++) begin
            drive(sent < 24, mkrow(sent % 8, 3 + sent / 8), 1'b1, 1'b0);
            if (i >= 16 && obs_ir !== 1'b0) bad_ir++;
            if (wfire) sent++;
        end
        nvec++; if (sent != 16) begin nerr++; $display("FAIL bp_accepted: got %0d rows want 16", sent); end
        nvec++; if (bad_ir != 0) begin nerr++; $display("FAIL bp_in_ready_low: %0d cycles high want 0", bad_ir); end
        for (int i = 0; i < 100 && got < 24; i++) begin
            drive(sent < 24, mkrow(sent % 8, 3 + sent / 8), 1'b1, 1'b1);
            if (saw_final && !rise_done) begin
                rise_done = 1;
                nvec++; if (obs_ir !== 1'b1) begin nerr++; $display("FAIL bp_ready_rise: in_ready=%b want 1", obs_ir); end
            end
            if (wfire) sent++;
            if (rfire) begin
                got++;
                if (!saw_final && exp_idx == CW'(N-1)) begin
                    saw_final = 1;
                    nvec++; if (obs_ir !== 1'b0) begin nerr++; $display("FAIL bp_no_bypass: in_ready=%b want 0", obs_ir); end
                end
                nvec++;
                if (!exp_ok || obs_data !== exp_v || obs_idx !== exp_idx || obs_last !== (exp_idx == CW'(N-1))) begin
                    nerr++; $display("FAIL bp_read: idx %0d data %h last %b want idx %0d data %h", obs_idx, obs_data, obs_last, exp_idx, exp_v);
                end
            end
        end
        nvec++; if (got != 24 || sent != 24) begin nerr++; $display("FAIL bp_drain: got %0d sent %0d want 24/24", got, sent); end
    endtask

    task automatic test_streaming();
        int sent = 0, got = 0, drv = 0;
        bit ir_drop = 0;
        while (got < 80 && drv < 120) begin
            drive(sent < 80, mkrow(sent % 8, 6 + sent / 8), ((sent / 8) % 2) == 0, 1'b1);
            if (sent < 80 && obs_ir !== 1'b1) ir_drop = 1;
            if (wfire) sent++;
            if (rfire) begin
                got++;
                nvec++;
                if (!exp_ok || obs_data !== exp_v || obs_idx !== exp_idx || obs_last !== (exp_idx == CW'(N-1))) begin
                    nerr++; $display("FAIL stream_read: idx %0d data %h want idx %0d data %h", obs_idx, obs_data, exp_idx, exp_v);
                end
            end
            drv++;
        end
        nvec++; if (ir_drop) begin nerr++; $display("FAIL stream_in_ready: dropped, want always 1"); end
        nvec++; if (got != 80 || drv != 88) begin nerr++; $display("FAIL stream_rate: %0d outputs in %0d cycles want 80 in 88", got, drv); end
    endtask

    task automatic test_random();
        int sent = 0, got = 0, drv = 0;
        logic ordy, tr, hold;
        logic [NW-1:0] hold_data;
        logic [CW-1:0] hold_idx;
        hold = 1'b0; hold_data = '0; hold_idx = '0;
        while (got < 1600 && drv < 20000) begin
            ordy = 1'($urandom_range(0, 1));
            tr   = (sent % 8 == 0) ? 1'((sent / 8) % 2) : 1'($urandom_range(0, 1));
            drive((sent < 1600) && ($urandom_range(0, 1) == 1), mkrow(sent % 8, sent / 8), tr, ordy);
            if (hold) begin
                nvec++;
                if (obs_ov !== 1'b1 || obs_data !== hold_data || obs_idx !== hold_idx) begin
                    nerr++; $display("FAIL rand_stable: data %h idx %0d want %h idx %0d", obs_data, obs_idx, hold_data, hold_idx);
                end
            end
            hold = obs_ov && !ordy; hold_data = obs_data; hold_idx = obs_idx;
            if (wfire) sent++;
            if (rfire) begin
                got++;
                nvec++;
                if (!exp_ok || obs_data !== exp_v || obs_idx !== exp_idx || obs_last !== (exp_idx == CW'(N-1))) begin
                    nerr++; $display("FAIL rand_read: vec %0d idx %0d data %h want idx %0d data %h", got, obs_idx, obs_data, exp_idx, exp_v);
                end
            end
            drv++;
        end
        nvec++; if (got != 1600) begin nerr++; $display("FAIL rand_count: got %0d outputs want 1600", got); end
    endtask

    task automatic test_reset_midblock();
        do_reset();
        for (int r = 0; r < N; r++) drive(1'b1, mkrow(r, 8), 1'b1, 1'b0);
        for (int r = 0; r < N; r++) drive(1'b1, mkrow(r, 9), 1'b0, 1'b0);
        for (int i = 0; i < N + 4; i++) begin
            drive(i >= N, mkrow(i - N, 10), 1'b1, 1'b1);
            nvec++;
            if (!rfire || !exp_ok || obs_data !== exp_v || obs_idx !== exp_idx) begin
                nerr++; $display("FAIL mid_read: step %0d fire %b data %h want %h", i, rfire, obs_data, exp_v);
            end
        end
        drive(1'b1, mkrow(4, 10), 1'b1, 1'b0);
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        nvec++; if (obs_ov !== 1'b0 || obs_ir !== 1'b1) begin nerr++; $display("FAIL mid_after_reset: out_valid=%b in_ready=%b want 0/1", obs_ov, obs_ir); end
        for (int r = 0; r < N; r++) drive(1'b1, mkrow(r, 11), 1'b1, 1'b0);
        for (int c = 0; c < N; c++) begin
            drive(1'b0, '0, 1'b0, 1'b1);
            nvec++;
            if (!rfire || !exp_ok || obs_data !== exp_v || obs_idx !== exp_idx || obs_last !== (c == N-1)) begin
                nerr++; $display("FAIL mid_new_block: col %0d fire %b data %h want %h", c, rfire, obs_data, exp_v);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1);
        nvec++; if (obs_ov !== 1'b0 || exp_q.size() != 0) begin nerr++; $display("FAIL mid_stale: out_valid=%b pending=%0d want 0/0", obs_ov, exp_q.size()); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; transpose = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single_transpose();
        test_passthrough();
        test_backpressure();
        test_streaming();
        test_random();
        test_reset_midblock();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
